// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-RAM load/store, memory-mapped timer, writeback triple.
// Optional timer block (TH/TL/TCON/SYSTICK) is built only when MEM_TIMER_EN is defined.
module mem_access_stage #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] TIMER_BASE = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_result_MEM,
    input  logic [31:0] store_data_MEM,
    input  logic        mem_read_MEM,
    input  logic        mem_write_MEM,
    input  logic        mem_to_reg_MEM,
    input  logic        reg_write_MEM,
    input  logic [4:0]  dest_reg_MEM,
    output logic [4:0]  write_regAddress_MEM,
    output logic [31:0] write_regValue_MEM,
    output logic        is_writeReg_MEM,
    output logic        addr_err,
    output logic        irq
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           ram [DEPTH];
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  access;
    logic                  misaligned;
    logic                  in_ram;
    logic                  in_timer;
    logic                  store_en;
    logic [31:0]           timer_rdata;
    logic [31:0]           load_data;

    assign word_addr  = alu_result_MEM[ADDR_WIDTH+1:2];
    assign access     = mem_read_MEM | mem_write_MEM;
    assign misaligned = alu_result_MEM[1:0] != 2'b00;
    assign in_ram     = (alu_result_MEM >> (ADDR_WIDTH + 2)) == 32'd0;
    assign addr_err   = ~reset & access & (misaligned | ~(in_ram | in_timer));
    assign store_en   = mem_write_MEM & ~addr_err & ~reset;

`ifdef MEM_TIMER_EN
    logic [31:0] th, tl, systick;
    logic [2:0]  tcon;
    logic [31:0] th_n, tl_n, systick_n;
    logic [2:0]  tcon_n;
    logic        hit_th, hit_tl, hit_tcon, hit_systick;
    logic        ovf_set;

    assign hit_th      = alu_result_MEM == TIMER_BASE;
    assign hit_tl      = alu_result_MEM == TIMER_BASE + 32'h4;
    assign hit_tcon    = alu_result_MEM == TIMER_BASE + 32'h8;
    assign hit_systick = alu_result_MEM == TIMER_BASE + 32'hC;
    assign in_timer    = hit_th | hit_tl | hit_tcon | hit_systick;
    assign irq         = ~reset & tcon[1] & tcon[2];

    // Counter/reload next state; software writes override the hardware update.
    always_comb begin
        th_n      = th;
        tl_n      = tl;
        tcon_n    = tcon;
        systick_n = systick + 32'd1;
        ovf_set   = tcon[0] & (tl == 32'hFFFF_FFFF) & tcon[1];
        if (tcon[0]) begin
            tl_n = (tl == 32'hFFFF_FFFF) ? th : tl + 32'd1;
        end
        if (ovf_set) begin
            tcon_n[2] = 1'b1;
        end
        if (store_en && hit_th) begin
            th_n = store_data_MEM;
        end
        if (store_en && hit_tl) begin
            tl_n = store_data_MEM;
        end
        if (store_en && hit_tcon) begin
            tcon_n = {store_data_MEM[2] | ovf_set, store_data_MEM[1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th      <= '0;
            tl      <= '0;
            tcon    <= '0;
            systick <= '0;
        end else begin
            th      <= th_n;
            tl      <= tl_n;
            tcon    <= tcon_n;
            systick <= systick_n;
        end
    end

    always_comb begin
        timer_rdata = '0;
        if (hit_th)      timer_rdata = th;
        if (hit_tl)      timer_rdata = tl;
        if (hit_tcon)    timer_rdata = {29'd0, tcon};
        if (hit_systick) timer_rdata = systick;
    end
`else
    assign in_timer    = 1'b0;
    assign timer_rdata = '0;
    assign irq         = 1'b0;
`endif

    // RAM contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (store_en && in_ram) begin
            ram[word_addr] <= store_data_MEM;
        end
    end

    always_comb begin
        load_data = '0;
        if (!addr_err) begin
            load_data = in_ram ? ram[word_addr] : timer_rdata;
        end
    end

    assign write_regAddress_MEM = dest_reg_MEM;
    assign write_regValue_MEM   = mem_to_reg_MEM ? load_data : alu_result_MEM;
    assign is_writeReg_MEM      = reg_write_MEM & ~reset & (dest_reg_MEM != 5'd0);

endmodule
